// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg : shared funct3 codes, FSM states and alignment helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b01:   return offset[0];
            2'b10:   return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// mem_lane_align : little-endian load extract/extend and sub-word store merge
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic [31:0] merged
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] mask;

    assign shamt   = {offset, 3'b000};
    assign shifted = word >> shamt;

    always_comb begin
        ldata = word;
        case (funct3)
            F3_B:    ldata = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ldata = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ldata = {24'h0, shifted[7:0]};
            F3_HU:   ldata = {16'h0, shifted[15:0]};
            default: ldata = word;
        endcase
    end

    assign mask   = ((funct3[1:0] == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
    assign merged = (word & ~mask) | ((wdata << shamt) & mask);

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit : load/store initiator with read-modify-write sub-word stores
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = 40000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_we,
    input  logic [31:0] mem_read_data
);

    state_t      state, state_next;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [31:0] wdata_q;
    logic [32:0] size;
    logic [32:0] end_addr;
    logic        illegal;
    logic        req_err;
    logic        accept;
    logic [31:0] ldata;
    logic [31:0] merged;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign mem_we     = (state == WRITE);
    assign accept     = req_valid & req_ready;

    always_comb begin
        case (req_funct3[1:0])
            2'b00:   size = 33'd1;
            2'b01:   size = 33'd2;
            default: size = 33'd4;
        endcase
    end

    // Store funct3 011 has no RV32I meaning, so it is rejected along with [2]=1.
    assign illegal  = req_store ? (req_funct3[2] | (req_funct3[1:0] == 2'b11))
                                : ((req_funct3[1:0] == 2'b11) | (req_funct3 == 3'b110));
    assign end_addr = {1'b0, req_addr} + size;
    assign req_err  = illegal | is_misaligned(req_funct3, req_addr[1:0])
                    | (end_addr > 33'(MEM_BYTES));

    mem_lane_align u_align (
        .word   (mem_read_data),
        .offset (offset_q),
        .funct3 (funct3_q),
        .wdata  (wdata_q),
        .ldata  (ldata),
        .merged (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)                           state_next = RESP;
                    else if (req_store && req_funct3 == F3_W) state_next = WRITE;
                    else                                   state_next = READ;
                end
            end
            READ:    state_next = store_q ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_q        <= 1'b0;
            funct3_q       <= 3'b000;
            offset_q       <= 2'b00;
            wdata_q        <= 32'h0;
            mem_addr       <= 32'h0;
            mem_write_data <= 32'h0;
            resp_rdata     <= 32'h0;
            resp_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        store_q    <= req_store;
                        funct3_q   <= req_funct3;
                        offset_q   <= req_addr[1:0];
                        wdata_q    <= req_wdata;
                        mem_addr   <= req_addr & ~32'h3;
                        resp_rdata <= 32'h0;
                        resp_err   <= req_err;
                        if (req_store && req_funct3 == F3_W) mem_write_data <= req_wdata;
                    end
                end
                READ: begin
                    if (store_q) mem_write_data <= merged;
                    else         resp_rdata     <= ldata;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
